// File: rtl/top_led.sv
// ---------------------------------------------------------------------------
// top_led : one node of a pulse-width-encoded LED daisy chain.
//
// The serial line carries one bit per high pulse: a long pulse (>= 4U) is a
// one, a short pulse is a zero. The first 24 bits after a latch gap belong to
// this node and are collected MSB-first. Every later bit is forwarded to the
// next node with its width intact. A low period of 32U marks the end of a
// frame: a complete word is presented on o_led_data, a partial one is dropped.
// U = 2^CWIDTH clocks. The input is synchronized and then debounced over a
// 2^DEBOUNCEWIDTH clock stability window before any decoding takes place.
// ---------------------------------------------------------------------------
module top_led #(
   parameter int DEBOUNCEWIDTH = 0,
   parameter int CWIDTH        = 0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_serial,
   output logic        o_serial,
   output logic [23:0] o_led_data
);

   // ------------------------------------------------------------------------
   // Widths and thresholds
   // ------------------------------------------------------------------------
   // Pulse counters are wide enough to reach 63U before saturating.
   localparam int CNT_W = CWIDTH + 6;
   // One extra bit keeps the debounce counter non-empty when DEBOUNCEWIDTH=0.
   localparam int DB_W  = DEBOUNCEWIDTH + 1;

   localparam logic [DB_W-1:0]  DB_ZERO  = {DB_W{1'b0}};
   localparam logic [DB_W-1:0]  DB_ONE   = {{(DB_W-1){1'b0}}, 1'b1};
   // Last count before the filter accepts a new level.
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'((32'd1 << DEBOUNCEWIDTH) - 32'd1);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   // High pulses of at least 4U decode as a one.
   localparam logic [CNT_W-1:0] ONE_MIN  = CNT_W'(32'd4 << CWIDTH);
   // The low count about to step onto 32U: the latch gap is reached this clock.
   localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'((32'd32 << CWIDTH) - 32'd1);

   localparam logic [4:0]       BIT_ZERO = 5'd0;
   localparam logic [4:0]       BIT_ONE  = 5'd1;
   localparam logic [4:0]       BIT_LAST = 5'd23;
   localparam logic [4:0]       BIT_FULL = 5'd24;

   // Saturating increment shared by the high and low pulse counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (&value) begin
         result = value;
      end else begin
         result = value + CNT_ONE;
      end
      return result;
   endfunction

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic             sync1_r;
   logic             sync2_r;
   logic             filt_r;
   logic             filt_d_r;
   logic [DB_W-1:0]  db_cnt_r;
   logic [CNT_W-1:0] high_cnt_r;
   logic [CNT_W-1:0] low_cnt_r;
   logic [23:0]      shift_r;
   logic [4:0]       bit_cnt_r;
   logic             full_r;
   logic [23:0]      led_r;
   logic             ser_out_r;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic             rise_s;
   logic             fall_s;
   logic             bit_val_s;
   logic             latch_s;
   logic [23:0]      shift_nxt_s;
   logic [4:0]       bit_cnt_nxt_s;
   logic             full_nxt_s;
   logic [23:0]      led_nxt_s;

   // Two-flop synchronizer: the raw line is asynchronous to i_clk.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= i_serial;
         sync2_r <= sync1_r;
      end
   end

   // Debounce: adopt the synchronized level only after it has differed for a full window.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         filt_r   <= 1'b0;
         db_cnt_r <= DB_ZERO;
      end else if (sync2_r != filt_r) begin
         if (db_cnt_r == DB_LAST) begin
            filt_r   <= sync2_r;
            db_cnt_r <= DB_ZERO;
         end else begin
            filt_r   <= filt_r;
            db_cnt_r <= db_cnt_r + DB_ONE;
         end
      end else begin
         filt_r   <= filt_r;
         db_cnt_r <= DB_ZERO;
      end
   end

   // Delayed copy of the filtered line for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         filt_d_r <= 1'b0;
      end else begin
         filt_d_r <= filt_r;
      end
   end

   assign rise_s = filt_r & ~filt_d_r;
   assign fall_s = ~filt_r & filt_d_r;

   // High counter: the rising-edge clock is the first high clock; the count is held while low
   // so the falling edge can read the full pulse width.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         high_cnt_r <= CNT_ZERO;
      end else if (rise_s) begin
         high_cnt_r <= CNT_ONE;
      end else if (filt_r) begin
         high_cnt_r <= sat_inc(high_cnt_r);
      end else begin
         high_cnt_r <= high_cnt_r;
      end
   end

   // Low counter: measures the current low period, cleared whenever the line is high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         low_cnt_r <= CNT_ZERO;
      end else if (filt_r) begin
         low_cnt_r <= CNT_ZERO;
      end else begin
         low_cnt_r <= sat_inc(low_cnt_r);
      end
   end

   assign bit_val_s = (high_cnt_r >= ONE_MIN);
   // Exactly one clock per gap sees the counter step from 32U-1 to 32U.
   assign latch_s   = ~filt_r & (low_cnt_r == GAP_M1);

   // Frame bookkeeping: collect the first 24 bits, then latch or discard at the gap.
   // A latch gap and a falling edge never coincide, since the edge clock has a zero low count.
   always_comb begin
      shift_nxt_s   = shift_r;
      bit_cnt_nxt_s = bit_cnt_r;
      full_nxt_s    = full_r;
      led_nxt_s     = led_r;
      if (latch_s) begin
         if (full_r) begin
            led_nxt_s = shift_r;
         end else begin
            led_nxt_s = led_r;
         end
         bit_cnt_nxt_s = BIT_ZERO;
         full_nxt_s    = 1'b0;
      end else if (fall_s && (bit_cnt_r < BIT_FULL)) begin
         shift_nxt_s   = {shift_r[22:0], bit_val_s};
         bit_cnt_nxt_s = bit_cnt_r + BIT_ONE;
         if (bit_cnt_r == BIT_LAST) begin
            full_nxt_s = 1'b1;
         end else begin
            full_nxt_s = full_r;
         end
      end else begin
         shift_nxt_s   = shift_r;
         bit_cnt_nxt_s = bit_cnt_r;
         full_nxt_s    = full_r;
      end
   end

   // Frame state registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shift_r   <= 24'h000000;
         bit_cnt_r <= BIT_ZERO;
         full_r    <= 1'b0;
         led_r     <= 24'h000000;
      end else begin
         shift_r   <= shift_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         full_r    <= full_nxt_s;
         led_r     <= led_nxt_s;
      end
   end

   // Forwarding: once the word is full, the filtered line passes through one clock late.
   // The falling edge that completes the word is already low, so it emits nothing.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ser_out_r <= 1'b0;
      end else begin
         ser_out_r <= full_r & filt_r;
      end
   end

   assign o_serial   = ser_out_r;
   assign o_led_data = led_r;

endmodule

// File: tb/tb_top_led.sv
// ---------------------------------------------------------------------------
// tb_top_led : self-checking bench for top_led.
// Node "dut" (DEBOUNCEWIDTH=0, CWIDTH=0) drives node "dn" through its
// o_serial; node "dut_db" (DEBOUNCEWIDTH=2, CWIDTH=1) gets its own line for
// the glitch scenario. Expected words come from the list of pulse widths
// that was sent: a pulse decodes to 1 when it lasts at least 4U clocks.
// ---------------------------------------------------------------------------
module tb_top_led;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ser;
   logic        ser_db;
   logic        os;
   logic        os_dn;
   logic        os_db;
   logic [23:0] led;
   logic [23:0] led_dn;
   logic [23:0] led_db;

   int n_pass  = 0;
   int n_total = 0;
   int ncyc    = 0;

   // Pulse list to be played: high and low width of each bit, and start time.
   int hq[$];
   int lq[$];
   int st[$];
   // Pulses observed on dut o_serial: first-high sample time and width.
   int fr_rise[$];
   int fr_w[$];
   int dut_high = 0;
   int db_high  = 0;

   logic [23:0] exp_led;
   logic [23:0] exp_dn;
   logic [23:0] exp_db;

   // o_serial of dut rises 3 clocks after the synchronizer's first sample
   // (2 sync flops, 1 filter clock, 1 output register), and is observed at
   // the following falling edge; counted in falling edges from the drive time.
   localparam int FWD_LAT = 5;

   always #5 clk = ~clk;

   top_led #(.DEBOUNCEWIDTH(0), .CWIDTH(0)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_serial(ser),
      .o_serial(os), .o_led_data(led));

   top_led #(.DEBOUNCEWIDTH(0), .CWIDTH(0)) dn (
      .i_clk(clk), .i_rst_n(rst_n), .i_serial(os),
      .o_serial(os_dn), .o_led_data(led_dn));

   top_led #(.DEBOUNCEWIDTH(2), .CWIDTH(1)) dut_db (
      .i_clk(clk), .i_rst_n(rst_n), .i_serial(ser_db),
      .o_serial(os_db), .o_led_data(led_db));

   // Output monitor, sampling on the falling edge.
   initial begin : mon
      logic prev;
      int   rise_at;
      prev    = 1'b0;
      rise_at = 0;
      forever begin
         @(negedge clk);
         ncyc++;
         if (os === 1'b1 && prev === 1'b0) begin
            rise_at = ncyc;
         end else if (os === 1'b0 && prev === 1'b1) begin
            fr_rise.push_back(rise_at);
            fr_w.push_back(ncyc - rise_at);
         end
         prev = os;
         if (os === 1'b1) dut_high++;
         if (os_db === 1'b1) db_high++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_q();
      hq.delete(); lq.delete(); st.delete();
      fr_rise.delete(); fr_w.delete();
      dut_high = 0;
      db_high  = 0;
   endtask

   task automatic add_word(input logic [23:0] w, input int h1, input int l1,
                           input int h0, input int l0);
      for (int i = 23; i >= 0; i--) begin
         if (w[i]) begin
            hq.push_back(h1); lq.push_back(l1);
         end else begin
            hq.push_back(h0); lq.push_back(l0);
         end
      end
   endtask

   // Random bit with random widths that still decode unambiguously at U=1.
   task automatic add_rand_bit();
      if ($urandom_range(1, 0) == 1) hq.push_back(int'($urandom_range(7, 4)));
      else                           hq.push_back(int'($urandom_range(3, 1)));
      lq.push_back(int'($urandom_range(8, 2)));
   endtask

   task automatic play(input int which);
      for (int i = 0; i < hq.size(); i++) begin
         st.push_back(ncyc);
         if (which == 0) ser = 1'b1; else ser_db = 1'b1;
         tick(hq[i]);
         if (which == 0) ser = 1'b0; else ser_db = 1'b0;
         tick(lq[i]);
      end
   endtask

   // Word carried by 24 pulses starting at index first.
   function automatic logic [23:0] model_word(input int first, input int thr);
      logic [23:0] w;
      w = 24'h000000;
      for (int i = 0; i < 24; i++) w = {w[22:0], hq[first + i] >= thr};
      return w;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; ser = 1'b0; ser_db = 1'b0;
      tick(3);
      n_total++;
      if ({os, led} !== 25'd0) $display("FAIL reset_dut got os=%b led=%h exp 0/000000", os, led);
      else n_pass++;
      n_total++;
      if ({os_dn, led_dn} !== 25'd0) $display("FAIL reset_dn got os=%b led=%h exp 0/000000", os_dn, led_dn);
      else n_pass++;
      n_total++;
      if ({os_db, led_db} !== 25'd0) $display("FAIL reset_db got os=%b led=%h exp 0/000000", os_db, led_db);
      else n_pass++;
      rst_n = 1'b1;
      tick(45);
      exp_led = 24'h000000; exp_dn = 24'h000000; exp_db = 24'h000000;
      n_total++;
      if (led !== exp_led || os !== 1'b0) $display("FAIL idle_after_reset got os=%b led=%h exp 0/%h", os, led, exp_led);
      else n_pass++;
   endtask

   task automatic test_single_frame();
      clear_q();
      add_word(24'hA5C3F0, 6, 2, 2, 6);
      play(0);
      tick(40);
      exp_led = model_word(0, 4);
      n_total++;
      if (led !== exp_led) $display("FAIL single_frame_led got %h exp %h", led, exp_led);
      else n_pass++;
      n_total++;
      if (dut_high !== 0) $display("FAIL single_frame_oserial got %0d high clocks exp 0", dut_high);
      else n_pass++;
      n_total++;
      if (led_dn !== exp_dn) $display("FAIL single_frame_dn got %h exp %h", led_dn, exp_dn);
      else n_pass++;
   endtask

   task automatic test_forward();
      int bad_w;
      int bad_l;
      clear_q();
      add_word(24'h112233, 6, 2, 2, 6);
      add_word(24'hABCDEF, 6, 2, 2, 6);
      play(0);
      tick(50);
      exp_led = model_word(0, 4);
      exp_dn  = model_word(24, 4);
      n_total++;
      if (led !== exp_led) $display("FAIL forward_led got %h exp %h", led, exp_led);
      else n_pass++;
      n_total++;
      if (led_dn !== exp_dn) $display("FAIL forward_downstream got %h exp %h", led_dn, exp_dn);
      else n_pass++;
      n_total++;
      if (fr_w.size() !== 24) $display("FAIL forward_pulse_count got %0d exp 24", fr_w.size());
      else n_pass++;
      bad_w = 0; bad_l = 0;
      for (int k = 0; k < fr_w.size() && k < 24; k++) begin
         if (fr_w[k] != hq[24 + k]) bad_w++;
         if (fr_rise[k] - st[24 + k] != FWD_LAT) bad_l++;
      end
      n_total++;
      if (bad_w !== 0) $display("FAIL forward_widths got %0d wrong widths exp 0", bad_w);
      else n_pass++;
      n_total++;
      if (bad_l !== 0) $display("FAIL forward_latency got %0d pulses off latency exp 0", bad_l);
      else n_pass++;
   endtask

   task automatic test_boundary();
      logic [23:0] w;
      for (int r = 0; r < 2; r++) begin
         clear_q();
         if (r == 0) w = 24'h5AA55A; else w = 24'($urandom);
         add_word(w, 4, 4, 3, 5);
         play(0);
         tick(50);
         exp_led = model_word(0, 4);
         n_total++;
         if (led !== exp_led) $display("FAIL boundary_%0d got %h exp %h", r, led, exp_led);
         else n_pass++;
      end
   endtask

   task automatic test_partial();
      clear_q();
      repeat (10) add_rand_bit();
      play(0);
      tick(50);
      n_total++;
      if (led !== exp_led) $display("FAIL partial_keep got %h exp %h", led, exp_led);
      else n_pass++;
      n_total++;
      if (dut_high !== 0) $display("FAIL partial_oserial got %0d high clocks exp 0", dut_high);
      else n_pass++;
      clear_q();
      repeat (24) add_rand_bit();
      play(0);
      tick(50);
      exp_led = model_word(0, 4);
      n_total++;
      if (led !== exp_led) $display("FAIL partial_then_full got %h exp %h", led, exp_led);
      else n_pass++;
   endtask

   task automatic test_random();
      int n;
      for (int f = 0; f < 4; f++) begin
         clear_q();
         n = int'($urandom_range(48, 24));
         repeat (n) add_rand_bit();
         play(0);
         tick(50);
         exp_led = model_word(0, 4);
         if (n >= 48) exp_dn = model_word(24, 4);
         n_total++;
         if (led !== exp_led) $display("FAIL random_%0d_led got %h exp %h", f, led, exp_led);
         else n_pass++;
         n_total++;
         if (led_dn !== exp_dn) $display("FAIL random_%0d_dn got %h exp %h", f, led_dn, exp_dn);
         else n_pass++;
         n_total++;
         if (fr_w.size() !== n - 24) $display("FAIL random_%0d_pulses got %0d exp %0d", f, fr_w.size(), n - 24);
         else n_pass++;
      end
   endtask

   task automatic test_glitch();
      clear_q();
      add_word(24'($urandom), 10, 6, 5, 11);
      play(1);
      tick(80);
      exp_db = model_word(0, 8);
      n_total++;
      if (led_db !== exp_db) $display("FAIL glitch_prior_frame got %h exp %h", led_db, exp_db);
      else n_pass++;
      clear_q();
      repeat (6) begin
         ser_db = 1'b1; tick(int'($urandom_range(3, 1)));
         ser_db = 1'b0; tick(int'($urandom_range(10, 5)));
      end
      tick(80);
      n_total++;
      if (led_db !== exp_db) $display("FAIL glitch_led got %h exp %h", led_db, exp_db);
      else n_pass++;
      n_total++;
      if (db_high !== 0) $display("FAIL glitch_oserial got %0d high clocks exp 0", db_high);
      else n_pass++;
      // Glitches immediately before a frame: any decoded glitch would shift the word.
      clear_q();
      repeat (5) begin
         ser_db = 1'b1; tick(int'($urandom_range(3, 1)));
         ser_db = 1'b0; tick(int'($urandom_range(10, 5)));
      end
      add_word(24'($urandom), 10, 6, 5, 11);
      play(1);
      tick(80);
      exp_db = model_word(0, 8);
      n_total++;
      if (led_db !== exp_db) $display("FAIL glitch_then_frame got %h exp %h", led_db, exp_db);
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      clear_q();
      add_word(24'($urandom), 6, 2, 2, 6);
      while (hq.size() > 12) begin
         void'(hq.pop_back());
         void'(lq.pop_back());
      end
      play(0);
      rst_n = 1'b0;
      #1;
      exp_led = 24'h000000; exp_dn = 24'h000000; exp_db = 24'h000000;
      n_total++;
      if ({os, led} !== 25'd0) $display("FAIL midreset_dut got os=%b led=%h exp 0/000000", os, led);
      else n_pass++;
      n_total++;
      if ({os_dn, led_dn, os_db, led_db} !== 50'd0) $display("FAIL midreset_others got dn=%h db=%h exp 000000", led_dn, led_db);
      else n_pass++;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      clear_q();
      add_word(24'($urandom), 6, 2, 2, 6);
      play(0);
      tick(50);
      exp_led = model_word(0, 4);
      n_total++;
      if (led !== exp_led) $display("FAIL midreset_new_frame got %h exp %h", led, exp_led);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_forward();
      test_boundary();
      test_partial();
      test_random();
      test_glitch();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
